// File: rtl/seq_priority_encoder.sv
// Sequential lowest-set-bit encoder: scans a captured 2**N-bit vector 2**C bits
// per cycle over a fixed K = 2**(N-C) cycles, then pulses done with e/valid.
module seq_priority_encoder #(
    parameter int N = 3,
    parameter int C = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2**N-1:0]  d,
    output logic             busy,
    output logic             done,
    output logic             valid,
    output logic [N-1:0]     e
);

    localparam int W     = 2**N;
    localparam int CW    = 2**C;
    localparam int K     = 2**(N-C);
    localparam int CNT_W = (N > C) ? (N - C) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [W-1:0]     vec_q;
    logic [CNT_W-1:0] cnt_q;
    logic             found_q;
    logic [N-1:0]     idx_q;

    logic [N-1:0]     chunk_base;
    logic [CW-1:0]    chunk;
    logic [N-1:0]     chunk_off;
    logic             chunk_hit;
    logic             last_chunk;
    logic [N-1:0]     idx_d;
    logic             found_d;

    // Evaluate the current chunk; the first set bit found in any chunk is kept.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
        chunk_base = N'(cnt_q) << C;
        chunk      = vec_q[chunk_base +: CW];
        chunk_hit  = |chunk;
        chunk_off  = '0;
        for (int i = CW - 1; i >= 0; i--) begin
            if (chunk[i]) chunk_off = N'(i);
        end
        found_d    = found_q | chunk_hit;
        idx_d      = idx_q;
        if (!found_q && chunk_hit) idx_d = chunk_base + chunk_off;
        last_chunk = (cnt_q == CNT_W'(K - 1));
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = SCAN;
            SCAN:    if (last_chunk) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec_q   <= '0;
            cnt_q   <= '0;
            found_q <= 1'b0;
            idx_q   <= '0;
            e       <= '0;
            valid   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        vec_q   <= d;
                        cnt_q   <= '0;
                        found_q <= 1'b0;
                        idx_q   <= '0;
                    end
                end
                SCAN: begin
                    cnt_q   <= cnt_q + CNT_W'(1);
                    found_q <= found_d;
                    idx_q   <= idx_d;
                    // Results are published only on the edge that enters DONE.
                    if (last_chunk) begin
                        e     <= idx_d;
                        valid <= found_d;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_priority_encoder.sv
// Directed bench for seq_priority_encoder: table of vectors on an N=3/C=1 instance,
// plus hand sequences for busy restart, mid-scan reset and a C=N instance.
module tb_seq_priority_encoder;

    localparam int N  = 3;
    localparam int K1 = 4;   // scan length for C=1

    logic       clk = 1'b0;
    logic       rst;
    logic       start, start3;
    logic [7:0] d, d3;
    logic       busy, done, valid;
    logic       busy3, done3, valid3;
    logic [2:0] e, e3;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seq_priority_encoder #(.N(N), .C(1)) dut (
        .clk(clk), .rst(rst), .start(start), .d(d),
        .busy(busy), .done(done), .valid(valid), .e(e)
    );

    seq_priority_encoder #(.N(N), .C(3)) dut_c3 (
        .clk(clk), .rst(rst), .start(start3), .d(d3),
        .busy(busy3), .done(done3), .valid(valid3), .e(e3)
    );

    typedef struct {
        logic [7:0] vec;
        logic [2:0] exp_e;
        logic       exp_valid;
    } vec_t;

    vec_t vectors[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One scan on the C=1 instance. If poke is set, start is re-asserted with
    // d=8'h01 during the first busy cycle, which must be ignored.
    task automatic scan_c1(input logic [7:0] vec, input logic [2:0] exp_e,
                           input logic exp_valid, input bit poke);
        int pulses;
        int at;
        pulses = 0;
        at     = -1;
        @(negedge clk);
        start = 1'b1;
        d     = vec;
        @(posedge clk);                       // accepting edge t0
        for (int k = 0; k <= K1 + 2; k++) begin
            @(negedge clk);                   // after edge t0+k
            if (k == 0) begin
                start = poke;
                if (poke) d = 8'h01;
            end else if (k == 1) begin
                start = 1'b0;
                d     = ~vec;
            end
            if (done) begin
                pulses++;
                at = k;
            end
            check($sformatf("busy[%0h,k=%0d]", vec, k), busy, (k <= K1));
        end
        check($sformatf("done_count[%0h]", vec), pulses, 1);
        check($sformatf("done_edge[%0h]", vec), at, K1);
        check($sformatf("e[%0h]", vec), e, exp_e);
        check($sformatf("valid[%0h]", vec), valid, exp_valid);
    endtask

    initial begin
        int first;
        int pulses;

        rst = 1'b1; start = 1'b0; d = '0; start3 = 1'b0; d3 = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", valid, 0);
        check("rst_e", e, 0);
        check("rst_busy3", busy3, 0);
        rst = 1'b0;

        vectors.push_back('{8'b0010_0100, 3'd2, 1'b1});
        vectors.push_back('{8'h80, 3'd7, 1'b1});
        vectors.push_back('{8'h00, 3'd0, 1'b0});
        vectors.push_back('{8'hFF, 3'd0, 1'b1});
        vectors.push_back('{8'h0C, 3'd2, 1'b1});
        vectors.push_back('{8'hA0, 3'd5, 1'b1});
        vectors.push_back('{8'h03, 3'd0, 1'b1});
        vectors.push_back('{8'h48, 3'd3, 1'b1});
        for (int i = 0; i < 8; i++) begin
            logic [7:0] one;
            one = 8'd1 << i;                  // decoder output for index i
            vectors.push_back('{one, 3'(i), 1'b1});
        end

        foreach (vectors[i])
            scan_c1(vectors[i].vec, vectors[i].exp_e, vectors[i].exp_valid, 1'b0);

        // Held outputs after done, then restart attempt while busy.
        @(negedge clk);
        check("hold_e", e, 3'd7);
        check("hold_valid", valid, 1);
        scan_c1(8'h08, 3'd3, 1'b1, 1'b1);

        // Reset two cycles after start abandons the scan.
        @(negedge clk);
        start = 1'b1;
        d     = 8'h10;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_valid", valid, 0);
        check("midrst_e", e, 0);
        pulses = 0;
        repeat (K1 + 3) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("midrst_no_done", pulses, 0);
        scan_c1(8'h02, 3'd1, 1'b1, 1'b0);

        // C=N: single scan cycle; start held gives a done every 3 cycles.
        @(negedge clk);
        start3 = 1'b1;
        d3     = 8'b0110_0000;
        @(posedge clk);
        first = -1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done3 && first < 0) first = k;
            if (first >= 0) begin
                check($sformatf("c3_done[k=%0d]", k), done3, ((k - first) % 3 == 0));
                if (done3) begin
                    check($sformatf("c3_e[k=%0d]", k), e3, 3'd5);
                    check($sformatf("c3_valid[k=%0d]", k), valid3, 1);
                end
            end
        end
        check("c3_first_done", first, 1);
        start3 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_priority_encoder.md
Name: seq_priority_encoder

Overview:
- Sequential inverse of the one-hot decoder: converts a 2**N-bit request/one-hot vector into the binary index of its lowest set bit, plus a valid flag.
- Scans 2**C bits per cycle over a fixed, data-independent number of cycles. This keeps gate count low and timing oblivious for MPC/garbled-circuit auction flows, where it selects the winner slot from a comparison mask.
- Start/done handshake toward the auction controller.

Parameters:
- N, 3, index width; input vector is 2**N bits.
- C, 1, log2 of bits examined per cycle; constraint 0 <= C <= N. Scan length K = 2**(N-C) cycles.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request to encode; sampled only in IDLE.
- d  input  2**N  vector to encode; captured on the accepted start edge.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse; e and valid are final when high.
- valid  output  1  1 if the captured d had any bit set.
- e  output  N  index of the lowest set bit of the captured d; 0 if none set.

Behaviour:
- Reset:
  - rst high at a clock edge forces state=IDLE.
  - Clears busy, done, valid, e, the chunk counter, the found flag and the captured vector to 0.
  - rst has priority over every other input, including mid-scan. A scan in progress is abandoned and no done is produced.
- States:
  - IDLE -> SCAN on start=1. At that edge (t0), d is latched into an internal register, cnt=0, found=0, and the index accumulator is 0.
  - SCAN: at each edge, evaluate chunk cnt = bits [cnt*2**C +: 2**C] of the latched vector.
    - If found=0 and the chunk is nonzero: index <= cnt*2**C + (lowest set position within chunk), found <= 1.
    - Otherwise index and found hold.
    - cnt increments by 1.
    - At the edge that evaluates chunk K-1 (edge t0+K): state -> DONE; e <= final index; valid <= final found.
  - DONE: done=1 for exactly this one cycle (between edges t0+K and t0+K+1). Next edge -> IDLE.
- Latency:
  - done is high in the cycle following edge t0+K, i.e. K+1 edges after start is sampled.
  - The scan is fixed-length with no early termination, even when bit 0 is set.
- Priority: the lowest index wins. A multi-hot vector yields its lowest set bit.
- Round trip: for a one-hot input, e equals the shift amount that the decoder used to produce it.
- All-zero input: valid=0, e=0, and done still pulses at the normal time.
- Output hold: e and valid hold their values after DONE until the next accepted start. They are overwritten only at the edge entering DONE.
- start while busy (SCAN or DONE): ignored; the latched d is unaffected. Changes on d after capture have no effect.
- start=1 held continuously: a new scan begins on the first edge in IDLE, giving back-to-back scans every K+2 cycles.
- C=N: K=1; the single SCAN cycle evaluates the whole vector; done occurs 2 edges after start.
- Widths: cnt is max(N-C,1) bits. Index arithmetic is N bits, with no overflow since cnt*2**C + offset <= 2**N-1.
- busy=1 from edge t0 through edge t0+K+1, exclusive of IDLE.

Test Plan:
- N=3, C=1, reset then start with d=8'b0010_0100 -> busy rises next cycle; done pulses exactly 5 edges after the start edge; e=2, valid=1; outputs hold after done.
- d=8'h80, then d=8'h00 in separate runs -> first run e=7, valid=1; second run e=0, valid=0 with the same done timing.
- Sweep e_in=0..7 through the decoder (N=3) into the block -> e==e_in, valid=1, and latency identical for every value.
- Start with d=8'h08 and, while busy, assert start again with d=8'h01 -> single done, e=3; second start ignored; no second done.
- Assert rst two cycles after start with d=8'h10 -> next cycle busy=0, done=0, valid=0, e=0; no done ever pulses. A following start with d=8'h02 yields e=1.
- N=3, C=3, start held high continuously with d=8'b0110_0000 -> done pulses every 3 cycles with e=5, valid=1.
